// File: rtl/ltl_report_collector.sv
// Timestamped report collector: samples automaton report lines on each run
// cycle, queues {ts, report_in} events in a FIFO, and tracks drops and sticky reports.
module ltl_report_collector #(
  parameter int NUM_REPORTS = 4,
  parameter int TS_WIDTH    = 16,
  parameter int DEPTH       = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  input  logic [NUM_REPORTS-1:0]          report_in,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [TS_WIDTH+NUM_REPORTS-1:0] out_data,
  output logic [NUM_REPORTS-1:0]          sticky_reports,
  output logic                            overflow,
  output logic [7:0]                      drop_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = TS_WIDTH + NUM_REPORTS;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [EW-1:0]       mem [DEPTH];
  logic [TS_WIDTH-1:0] ts;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  logic evt;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    evt  = run && (report_in != '0);
    full = (count == CNT_FULL);
    pop  = (count != '0) && out_ready;
    push = evt && (!full || pop);
    drop = evt && full && !pop;
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem[wr_ptr] <= {ts, report_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ts     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (run) begin
        ts <= ts + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sticky_reports <= '0;
      overflow       <= 1'b0;
      drop_count     <= '0;
    end else begin
      if (run) begin
        sticky_reports <= sticky_reports | report_in;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) begin
          drop_count <= drop_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ltl_report_collector.sv
// Directed bench for ltl_report_collector: default instance plus a 4-bit
// timestamp instance for wrap-around.
module tb_ltl_report_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  report_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [19:0] out_data;
  logic [3:0]  sticky_reports;
  logic        overflow;
  logic [7:0]  drop_count;

  logic        w_run = 1'b0;
  logic [3:0]  w_report = '0;
  logic        w_ready = 1'b0;
  logic        w_valid;
  logic [7:0]  w_data;
  logic [3:0]  w_sticky;
  logic        w_overflow;
  logic [7:0]  w_drop;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ltl_report_collector #(.NUM_REPORTS(4), .TS_WIDTH(16), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .run(run), .report_in(report_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sticky_reports(sticky_reports), .overflow(overflow), .drop_count(drop_count)
  );

  ltl_report_collector #(.NUM_REPORTS(4), .TS_WIDTH(4), .DEPTH(8)) dut_w (
    .clk(clk), .reset(reset), .run(w_run), .report_in(w_report),
    .out_valid(w_valid), .out_ready(w_ready), .out_data(w_data),
    .sticky_reports(w_sticky), .overflow(w_overflow), .drop_count(w_drop)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0; report_in = '0; out_ready = 1'b0;
    w_run = 1'b0; w_report = '0; w_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (sticky_reports !== 4'b0000) begin n_bad++; $display("FAIL reset_sticky: got %b want 0000", sticky_reports); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL reset_w_valid: got %b want 0", w_valid); end
  endtask

  task automatic test_single_event();
    int vc;
    logic [19:0] seen;
    do_reset();
    vc = 0; seen = '0;
    run = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      if (c > 5) begin
        run = 1'b0;
        report_in = '0;
      end else begin
        report_in = (c == 3) ? 4'b0100 : 4'b0000;
      end
      step();
      if (out_valid) begin
        vc++;
        seen = out_data;
      end
      if (c == 3) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: got %b want 1", out_valid); end
      end
    end
    n_cmp++; if (vc !== 1) begin n_bad++; $display("FAIL single_valid_cycles: got %0d want 1", vc); end
    n_cmp++; if (seen !== {16'd2, 4'b0100}) begin n_bad++; $display("FAIL single_data: got %h want %h", seen, {16'd2, 4'b0100}); end
    n_cmp++; if (sticky_reports !== 4'b0100) begin n_bad++; $display("FAIL single_sticky: got %b want 0100", sticky_reports); end
  endtask

  task automatic test_overflow();
    do_reset();
    run = 1'b1; report_in = 4'b0001; out_ready = 1'b0;
    repeat (10) step();
    run = 1'b0; report_in = '0;
    step();
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL ovf_drop: got %0d want 2", drop_count); end
    n_cmp++; if (out_data !== {16'd0, 4'b0001}) begin n_bad++; $display("FAIL ovf_head_stable: got %h want %h", out_data, {16'd0, 4'b0001}); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== {16'(i), 4'b0001}) begin n_bad++; $display("FAIL ovf_drain_data[%0d]: got %h want %h", i, out_data, {16'(i), 4'b0001}); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: got %b want 0", out_valid); end
    n_cmp++; if (drop_count !== 8'd2) begin n_bad++; $display("FAIL ovf_drop_sticky: got %0d want 2", drop_count); end
  endtask

  task automatic test_full_push_pop();
    logic [19:0] exp;
    do_reset();
    run = 1'b1; report_in = 4'b0001; out_ready = 1'b0;
    repeat (8) step();
    report_in = 4'b0010; out_ready = 1'b1;
    step();
    run = 1'b0; report_in = '0;
    n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL fpp_drop: got %0d want 0", drop_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_overflow: got %b want 0", overflow); end
    for (int i = 1; i <= 8; i++) begin
      exp = (i == 8) ? {16'd8, 4'b0010} : {16'(i), 4'b0001};
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== exp) begin n_bad++; $display("FAIL fpp_data[%0d]: got %h want %h", i, out_data, exp); end
      step();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL fpp_count8: got valid %b want 0 after 8 pops", out_valid); end
  endtask

  task automatic test_run_gating();
    do_reset();
    run = 1'b1; report_in = '0; out_ready = 1'b0;
    repeat (3) step();
    run = 1'b0; report_in = 4'b1111;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL gate_valid: got %b want 0", out_valid); end
    n_cmp++; if (sticky_reports !== 4'b0000) begin n_bad++; $display("FAIL gate_sticky: got %b want 0000", sticky_reports); end
    run = 1'b1; report_in = 4'b0010;
    step();
    run = 1'b0; report_in = '0;
    n_cmp++; if (out_data !== {16'd3, 4'b0010}) begin n_bad++; $display("FAIL gate_ts: got %h want %h", out_data, {16'd3, 4'b0010}); end
    n_cmp++; if (sticky_reports !== 4'b0010) begin n_bad++; $display("FAIL gate_sticky_after: got %b want 0010", sticky_reports); end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    w_run = 1'b1; w_ready = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      w_report = (c >= 16) ? 4'b1000 : 4'b0000;
      step();
    end
    w_run = 1'b0; w_report = '0;
    n_cmp++; if (w_data !== 8'hF8) begin n_bad++; $display("FAIL wrap_first: got %h want f8", w_data); end
    w_ready = 1'b1;
    step();
    n_cmp++; if (w_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_second_valid: got %b want 1", w_valid); end
    n_cmp++; if (w_data !== 8'h08) begin n_bad++; $display("FAIL wrap_second: got %h want 08", w_data); end
    step();
    n_cmp++; if (w_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty: got %b want 0", w_valid); end
    w_ready = 1'b0;
  endtask

  task automatic test_drop_saturate();
    do_reset();
    run = 1'b1; report_in = 4'b1000; out_ready = 1'b0;
    repeat (8 + 254) step();
    n_cmp++; if (drop_count !== 8'd254) begin n_bad++; $display("FAIL sat_254: got %0d want 254", drop_count); end
    repeat (40) step();
    run = 1'b0; report_in = '0;
    n_cmp++; if (drop_count !== 8'd255) begin n_bad++; $display("FAIL sat_255: got %0d want 255", drop_count); end
    n_cmp++; if (sticky_reports !== 4'b1000) begin n_bad++; $display("FAIL sat_sticky: got %b want 1000", sticky_reports); end
    n_cmp++; if (out_data !== {16'd0, 4'b1000}) begin n_bad++; $display("FAIL sat_head: got %h want %h", out_data, {16'd0, 4'b1000}); end
  endtask

  task automatic test_reset_mid();
    // Flags are still set from the saturation scenario when this starts.
    run = 1'b0; report_in = '0; out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_cmp++; if (drop_count !== 8'd0) begin n_bad++; $display("FAIL rst_drop_clear: got %0d want 0", drop_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf_clear: got %b want 0", overflow); end
    run = 1'b1; report_in = 4'b0101;
    repeat (3) step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rst_queued: got %b want 1", out_valid); end
    reset = 1'b1; run = 1'b1; report_in = 4'b1111; out_ready = 1'b1;
    step();
    reset = 1'b0; run = 1'b0; report_in = '0; out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (sticky_reports !== 4'b0000) begin n_bad++; $display("FAIL rst_mid_sticky: got %b want 0000", sticky_reports); end
    n_cmp++; if (overflow !== 1'b0 || drop_count !== 8'd0) begin n_bad++; $display("FAIL rst_mid_flags: got %b/%0d want 0/0", overflow, drop_count); end
    run = 1'b1; report_in = 4'b0001;
    step();
    run = 1'b0; report_in = '0;
    n_cmp++; if (out_data !== {16'd0, 4'b0001}) begin n_bad++; $display("FAIL rst_next_ts: got %h want %h", out_data, {16'd0, 4'b0001}); end
    n_cmp++; if (sticky_reports !== 4'b0001) begin n_bad++; $display("FAIL rst_next_sticky: got %b want 0001", sticky_reports); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_overflow();
    test_full_push_pop();
    test_run_gating();
    test_ts_wrap();
    test_drop_saturate();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
